// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   T-state microcode sequencer that drives the datapath control word. It
//   replaces hand-set control lines with four operating states: MANUAL
//   (control word taken from manual_ctrl), STEP (one T-state per step_btn
//   press), RUN (one T-state every DIV clocks) and HALTED (left only by reset).
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   mode          00 MANUAL, 01 STEP, 10 RUN, 11 treated as STEP
//   step_btn      debounced, synchronous step request level
//   manual_ctrl   control word used while in MANUAL
//   opcode        current instruction opcode
//   flag_c/flag_z ALU carry / zero flags
//   rom_addr      microcode address {flag_c, flag_z, opcode, step_idx}
//   rom_data      microcode word, combinational from rom_addr
//   ctrl          control word to the datapath
//   tick          one-cycle latch enable for datapath registers
//   step_idx      current T-state
//   halted        high while in HALTED
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int OPC_W   = 4,
  parameter int CTRL_W  = 16,
  parameter int STEPS   = 5,
  parameter int STEP_W  = 3,
  parameter int DIV     = 50000000,
  parameter int HLT_BIT = 15,
  parameter int END_BIT = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic                      step_btn,
  input  logic [CTRL_W-1:0]         manual_ctrl,
  input  logic [OPC_W-1:0]          opcode,
  input  logic                      flag_c,
  input  logic                      flag_z,
  output logic [2+OPC_W+STEP_W-1:0] rom_addr,
  input  logic [CTRL_W-1:0]         rom_data,
  output logic [CTRL_W-1:0]         ctrl,
  output logic                      tick,
  output logic [STEP_W-1:0]         step_idx,
  output logic                      halted
);

  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             mode_state;
  logic               tick_reg;
  logic               halted_reg;
  logic               btn_q;
  logic [STEP_W-1:0]  step_reg;
  logic [DIV_W-1:0]   div_reg;

  logic               btn_rise;
  logic               div_done;
  logic               seq_active;
  logic               halt_now;
  logic               last_step;

  // Requested state for the mode switches; the reserved encoding acts as STEP.
  always_comb begin
    mode_state = ST_STEP;
    case (mode)
      2'b00:   mode_state = ST_MANUAL;
      2'b10:   mode_state = ST_RUN;
      default: mode_state = ST_STEP;
    endcase
  end

  // Control word source depends only on the current state, so it is stable
  // for the whole cycle in which the datapath latches it.
  always_comb begin
    ctrl = '0;
    case (state_reg)
      ST_MANUAL:        ctrl = manual_ctrl;
      ST_STEP, ST_RUN:  ctrl = rom_data;
      default:          ctrl = '0;
    endcase
  end

  assign rom_addr   = {flag_c, flag_z, opcode, step_reg};
  assign btn_rise   = step_btn & ~btn_q;
  assign div_done   = (div_reg == DIV_W'(DIV - 1));
  assign seq_active = (state_reg == ST_STEP) || (state_reg == ST_RUN);
  assign halt_now   = tick_reg && seq_active && ctrl[HLT_BIT];
  assign last_step  = (step_reg == STEP_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_MANUAL;
      step_reg   <= '0;
      tick_reg   <= 1'b0;
      halted_reg <= 1'b0;
      div_reg    <= '0;
      btn_q      <= 1'b0;
    end else begin
      // Edge detector always tracks the button so a level held across a
      // state change never produces a spurious tick.
      btn_q <= step_btn;

      if (state_reg == ST_HALTED) begin
        tick_reg <= 1'b0;
        div_reg  <= '0;
      end else if (halt_now) begin
        // HLT wins over END and over any tick that would start this cycle.
        state_reg  <= ST_HALTED;
        halted_reg <= 1'b1;
        step_reg   <= '0;
        tick_reg   <= 1'b0;
        div_reg    <= '0;
      end else begin
        state_reg <= mode_state;

        // T-state advance uses the state that produced this tick, even if
        // mode is changing at the same edge. MANUAL ticks consume no T-state.
        if (tick_reg && seq_active) begin
          if (ctrl[END_BIT] || last_step) begin
            step_reg <= '0;
          end else begin
            step_reg <= step_reg + STEP_W'(1);
          end
        end

        if (state_reg == ST_RUN) begin
          if (div_done) begin
            div_reg  <= '0;
            tick_reg <= 1'b1;
          end else begin
            div_reg  <= div_reg + DIV_W'(1);
            tick_reg <= 1'b0;
          end
        end else begin
          // Divider held at zero outside RUN, so RUN entry starts a full period.
          div_reg  <= '0;
          tick_reg <= btn_rise;
        end
      end
    end
  end

  assign tick     = tick_reg;
  assign step_idx = step_reg;
  assign halted   = halted_reg;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int OPC_W  = 4;
  localparam int CTRL_W = 16;
  localparam int STEP_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic              step_btn;
  logic [CTRL_W-1:0] manual_ctrl;
  logic [OPC_W-1:0]  opcode;
  logic              flag_c;
  logic              flag_z;
  logic [2+OPC_W+STEP_W-1:0] rom_addr;
  logic [CTRL_W-1:0] rom_data;
  logic [CTRL_W-1:0] ctrl;
  logic              tick;
  logic [STEP_W-1:0] step_idx;
  logic              halted;

  int checks = 0;
  int errors = 0;
  int tick_cnt;

  control_sequencer #(
    .OPC_W(OPC_W), .CTRL_W(CTRL_W), .STEPS(5), .STEP_W(STEP_W),
    .DIV(4), .HLT_BIT(15), .END_BIT(14)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .step_btn(step_btn),
    .manual_ctrl(manual_ctrl), .opcode(opcode), .flag_c(flag_c),
    .flag_z(flag_z), .rom_addr(rom_addr), .rom_data(rom_data),
    .ctrl(ctrl), .tick(tick), .step_idx(step_idx), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One step_btn press: tick must be high for exactly one cycle, then
  // step_idx must hold the expected T-state.
  task automatic pulse(input string tag, input logic [31:0] exp_idx);
    step_btn = 1'b1;
    cyc();
    check({tag, "_tick_hi"}, 32'(tick), 32'd1);
    step_btn = 1'b0;
    cyc();
    check({tag, "_tick_lo"}, 32'(tick), 32'd0);
    check({tag, "_idx"}, 32'(step_idx), exp_idx);
    $display("step %s: step_idx=%0d tick_seen=1", tag, step_idx);
  endtask

  initial begin
    rst_n       = 1'b0;
    mode        = 2'b01;
    step_btn    = 1'b0;
    manual_ctrl = 16'h1234;
    opcode      = 4'hA;
    flag_c      = 1'b1;
    flag_z      = 1'b0;
    rom_data    = 16'h0001;
    cyc();
    cyc();

    // Reset state: MANUAL, so ctrl follows manual_ctrl.
    check("rst_idx", 32'(step_idx), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'h1234);
    $display("reset: ctrl=0x%04h step_idx=%0d", ctrl, step_idx);

    rst_n = 1'b1;
    cyc();
    check("step_ctrl", 32'(ctrl), 32'h0001);

    // Test 1: single-step through a full instruction and wrap.
    pulse("t1_p1", 32'd1);
    pulse("t1_p2", 32'd2);
    pulse("t1_p3", 32'd3);
    pulse("t1_p4", 32'd4);
    pulse("t1_p5", 32'd0);
    pulse("t1_p6", 32'd1);

    // Holding the button yields a single tick.
    step_btn = 1'b1;
    cyc();
    check("hold_tick_hi", 32'(tick), 32'd1);
    cyc();
    check("hold_tick_lo1", 32'(tick), 32'd0);
    cyc();
    check("hold_tick_lo2", 32'(tick), 32'd0);
    cyc();
    check("hold_tick_lo3", 32'(tick), 32'd0);
    check("hold_idx", 32'(step_idx), 32'd2);
    step_btn = 1'b0;
    cyc();
    check("hold_release_tick", 32'(tick), 32'd0);
    $display("hold: step_idx=%0d", step_idx);

    pulse("t1_p7", 32'd3);

    // Test 5: rom_addr = {c,z,opcode,step_idx} = 10_1010_011.
    check("rom_addr", 32'(rom_addr), 32'b10_1010_011);
    $display("rom_addr: 0x%03h", rom_addr);

    // Test 4: MANUAL ticks use manual_ctrl and never consume T-states,
    // even when the microcode word would halt.
    mode = 2'b00;
    cyc();
    check("man_ctrl", 32'(ctrl), 32'h1234);
    rom_data = 16'hC000;
    step_btn = 1'b1;
    cyc();
    check("man_tick_hi", 32'(tick), 32'd1);
    check("man_ctrl_tick", 32'(ctrl), 32'h1234);
    step_btn = 1'b0;
    cyc();
    check("man_tick_lo", 32'(tick), 32'd0);
    check("man_idx", 32'(step_idx), 32'd3);
    check("man_halted", 32'(halted), 32'd0);
    mode     = 2'b01;
    rom_data = 16'h0002;
    check("man_ctrl_pre_switch", 32'(ctrl), 32'h1234);
    cyc();
    check("man_to_step_ctrl", 32'(ctrl), 32'h0002);
    $display("manual: ctrl after switch=0x%04h step_idx=%0d", ctrl, step_idx);

    // Test 2: RUN with DIV=4; ticks after E4, E8, ..., button ignored.
    mode = 2'b10;
    cyc();
    for (int k = 1; k <= 21; k++) begin
      step_btn = (k == 2 || k == 6 || k == 10);
      cyc();
      check($sformatf("run_tick_k%0d", k), 32'(tick), ((k % 4) == 0) ? 32'd1 : 32'd0);
      if (k == 12) check("run_idx_k12", 32'(step_idx), 32'd0);
    end
    step_btn = 1'b0;
    check("run_idx_k21", 32'(step_idx), 32'd3);
    $display("run: step_idx=%0d after 21 cycles", step_idx);

    // Test 6: asynchronous reset mid-divider clears everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_idx", 32'(step_idx), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_ctrl", 32'(ctrl), 32'h1234);
    cyc();
    rst_n = 1'b1;
    check("arst_rel_ctrl", 32'(ctrl), 32'h1234);
    cyc();
    check("arst_run_ctrl", 32'(ctrl), 32'h0002);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("rerun_tick_k%0d", k), 32'(tick), (k == 4) ? 32'd1 : 32'd0);
    end
    $display("async reset: resumed RUN, ctrl=0x%04h", ctrl);

    // Test 3: END and HLT microcode bits in STEP.
    rst_n = 1'b0;
    mode  = 2'b01;
    rom_data = 16'h0001;
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse("t3_p1", 32'd1);
    pulse("t3_p2", 32'd2);
    rom_data = 16'h4000;
    pulse("t3_end", 32'd0);
    rom_data = 16'h0001;
    pulse("t3_p3", 32'd1);
    pulse("t3_p4", 32'd2);
    rom_data = 16'hC000;
    pulse("t3_hlt", 32'd0);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_ctrl", 32'(ctrl), 32'h0000);

    tick_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      mode     = 2'(i / 6);
      step_btn = ((i % 2) == 1);
      cyc();
      if (tick) tick_cnt++;
    end
    step_btn = 1'b0;
    check("hlt_no_ticks", 32'(tick_cnt), 32'd0);
    check("hlt_still_halted", 32'(halted), 32'd1);
    check("hlt_ctrl_hold", 32'(ctrl), 32'h0000);
    check("hlt_idx_hold", 32'(step_idx), 32'd0);
    $display("halted: ticks seen=%0d halted=%0d", tick_cnt, halted);

    rst_n = 1'b0;
    #1;
    check("hlt_rst_halted", 32'(halted), 32'd0);
    check("hlt_rst_ctrl", 32'(ctrl), 32'h1234);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
